// File: rtl/ped_pkg.sv
// Shared types and lamp decoding for the pedestrian crossing head.
package ped_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WALK  = 3'd2,
        FLASH = 3'd3,
        CLEAR = 3'd4
    } ped_state_t;

    // Cars are stopped only on a clean red-only code; X or illegal codes are not stopped.
    function automatic logic lamps_stopped(input logic red, input logic orange, input logic green);
        return ((red & ~orange & ~green) === 1'b1);
    endfunction

endpackage

// File: rtl/ped_countdown.sv
// Down-counter for the WALK/FLASH phases: clear beats load beats decrement, never wraps.
module ped_countdown #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          en,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ped_crossing.sv
// Pedestrian crossing head driven from the car lamps; grants crossings only at the start of all-red.
module ped_crossing
    import ped_pkg::*;
#(
    parameter int WALK_TICKS  = 8,
    parameter int FLASH_TICKS = 4,
    parameter int CW          = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          red,
    input  logic          orange,
    input  logic          green,
    input  logic          ped_button,
    output logic          walk,
    output logic          dont_walk,
    output logic          wait_lamp,
    output logic [CW-1:0] countdown,
    output logic          abort
);

    ped_state_t    state, state_nxt;
    logic          pending, pending_nxt;
    logic          stopped, stopped_q, stop_rise;
    logic          walk_nxt, dont_walk_nxt, wait_nxt, abort_nxt;
    logic          cd_load, cd_clr, cd_en, cd_zero;
    logic [CW-1:0] cd_load_value;

    assign stopped   = lamps_stopped(red, orange, green);
    assign stop_rise = stopped & ~stopped_q;

    always_comb begin
        state_nxt     = state;
        pending_nxt   = pending;
        walk_nxt      = walk;
        dont_walk_nxt = dont_walk;
        wait_nxt      = wait_lamp;
        abort_nxt     = 1'b0;
        cd_load       = 1'b0;
        cd_clr        = 1'b0;
        cd_en         = 1'b0;
        cd_load_value = '0;
        case (state)
            IDLE: begin
                walk_nxt      = 1'b0;
                dont_walk_nxt = 1'b1;
                if (ped_button) begin
                    state_nxt = REQ;
                    wait_nxt  = 1'b1;
                end
            end
            REQ: begin
                if (stop_rise) begin
                    state_nxt     = WALK;
                    cd_load       = 1'b1;
                    cd_load_value = CW'(WALK_TICKS - 1);
                    wait_nxt      = 1'b0;
                    walk_nxt      = 1'b1;
                    dont_walk_nxt = 1'b0;
                end
            end
            WALK: begin
                if (ped_button) pending_nxt = 1'b1;
                if (!stopped) begin
                    // Abort outranks the tick: counter is cleared, not decremented.
                    state_nxt     = CLEAR;
                    abort_nxt     = 1'b1;
                    walk_nxt      = 1'b0;
                    dont_walk_nxt = 1'b1;
                    cd_clr        = 1'b1;
                end else if (tick) begin
                    if (cd_zero) begin
                        state_nxt     = FLASH;
                        cd_load       = 1'b1;
                        cd_load_value = CW'(FLASH_TICKS - 1);
                        walk_nxt      = 1'b0;
                        dont_walk_nxt = 1'b1;
                    end else begin
                        cd_en = 1'b1;
                    end
                end
            end
            FLASH: begin
                if (ped_button) pending_nxt = 1'b1;
                if (!stopped) begin
                    state_nxt     = CLEAR;
                    abort_nxt     = 1'b1;
                    walk_nxt      = 1'b0;
                    dont_walk_nxt = 1'b1;
                    cd_clr        = 1'b1;
                end else if (tick) begin
                    if (cd_zero) begin
                        state_nxt     = CLEAR;
                        dont_walk_nxt = 1'b1;
                    end else begin
                        dont_walk_nxt = ~dont_walk;
                        cd_en         = 1'b1;
                    end
                end
            end
            CLEAR: begin
                walk_nxt      = 1'b0;
                dont_walk_nxt = 1'b1;
                if (ped_button) pending_nxt = 1'b1;
                if (!stopped) begin
                    // A press on the exit cycle still counts as a queued request.
                    state_nxt   = (pending | ped_button) ? REQ : IDLE;
                    wait_nxt    = pending | ped_button;
                    pending_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt     = IDLE;
                walk_nxt      = 1'b0;
                dont_walk_nxt = 1'b1;
                wait_nxt      = 1'b0;
                pending_nxt   = 1'b0;
                cd_clr        = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= 1'b0;
            stopped_q <= 1'b0;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            wait_lamp <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            stopped_q <= stopped;
            walk      <= walk_nxt;
            dont_walk <= dont_walk_nxt;
            wait_lamp <= wait_nxt;
            abort     <= abort_nxt;
        end
    end

    ped_countdown #(.CW(CW)) u_countdown (
        .clk        (clk),
        .reset      (reset),
        .load       (cd_load),
        .load_value (cd_load_value),
        .en         (cd_en),
        .clr        (cd_clr),
        .count      (countdown),
        .zero       (cd_zero)
    );

endmodule

// File: tb/tb_ped_crossing.sv
// Scoreboarded bench for ped_crossing with WALK_TICKS=3, FLASH_TICKS=2, CW=2.
module tb_ped_crossing;
    import ped_pkg::*;

    localparam int WT = 3;
    localparam int FT = 2;
    localparam int CW = 2;
    localparam int EW = 4 + 4 + CW + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          red = 1'b0;
    logic          orange = 1'b0;
    logic          green = 1'b0;
    logic          ped_button = 1'b0;
    logic          walk, dont_walk, wait_lamp, abort;
    logic [CW-1:0] countdown;

    int total = 0;
    int bad = 0;

    // {pending, state, walk, dont_walk, wait_lamp, countdown, abort}
    logic [EW-1:0] exp_q[$];

    ped_state_t    m_state = IDLE;
    logic          m_pend = 1'b0, m_sq = 1'b0;
    logic          m_walk = 1'b0, m_dw = 1'b1, m_wl = 1'b0, m_ab = 1'b0;
    logic [CW-1:0] m_cd = '0;

    ped_crossing #(.WALK_TICKS(WT), .FLASH_TICKS(FT), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .red        (red),
        .orange     (orange),
        .green      (green),
        .ped_button (ped_button),
        .walk       (walk),
        .dont_walk  (dont_walk),
        .wait_lamp  (wait_lamp),
        .countdown  (countdown),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expd);
        total++;
        if (obs !== expd) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, expd, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic t, input logic r, input logic o,
                              input logic g, input logic b);
        logic st, rise;
        st   = r & ~o & ~g;
        rise = st & ~m_sq;
        if (rst) begin
            m_state = IDLE; m_pend = 0; m_sq = 0;
            m_walk = 0; m_dw = 1; m_wl = 0; m_cd = '0; m_ab = 0;
            return;
        end
        m_ab = 0;
        case (m_state)
            IDLE: if (b) begin m_state = REQ; m_wl = 1; end
            REQ: if (rise) begin
                m_state = WALK; m_cd = CW'(WT - 1); m_wl = 0; m_walk = 1; m_dw = 0;
            end
            WALK, FLASH: begin
                if (b) m_pend = 1;
                if (!st) begin
                    m_state = CLEAR; m_ab = 1; m_walk = 0; m_dw = 1; m_cd = '0;
                end else if (t && m_state == WALK) begin
                    if (m_cd == 0) begin
                        m_state = FLASH; m_cd = CW'(FT - 1); m_walk = 0; m_dw = 1;
                    end else m_cd = m_cd - 1'b1;
                end else if (t) begin
                    if (m_cd == 0) begin m_state = CLEAR; m_dw = 1; end
                    else begin m_dw = ~m_dw; m_cd = m_cd - 1'b1; end
                end
            end
            CLEAR: begin
                if (b) m_pend = 1;
                if (!st) begin
                    m_wl = m_pend;
                    m_state = m_pend ? REQ : IDLE;
                    m_pend = 0;
                end
            end
            default: m_state = IDLE;
        endcase
        m_sq = st;
    endtask

    // One clock: drive at negedge, predict, then compare just after the posedge.
    task automatic cyc(input logic rst, input logic t, input logic r, input logic o,
                       input logic g, input logic b);
        logic [EW-1:0] e;
        @(negedge clk);
        reset = rst; tick = t; red = r; orange = o; green = g; ped_button = b;
        model_step(rst, t, r, o, g, b);
        exp_q.push_back({m_pend, 1'b0, m_state, m_walk, m_dw, m_wl, m_cd, m_ab});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("outputs", 16'({walk, dont_walk, wait_lamp, countdown, abort}), 16'(e[CW+3:0]));
        check("state", 16'(dut.state), 16'(e[CW+6:CW+4]));
        check("pending", 16'(dut.pending), 16'(e[EW-1]));
        check("walk_excl", 16'(walk & dont_walk), 16'd0);
    endtask

    task automatic run_red(input int n);
        for (int i = 0; i < n; i++) cyc(0, 1, 1, 0, 0, 0);
    endtask

    initial begin
        // 1: reset
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        // 2: full crossing
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 0, 1, 0);
        run_red(12);
        cyc(0, 1, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 1, 0);
        // 3: press during stable red waits for the next red start
        run_red(3);
        cyc(0, 1, 1, 0, 0, 1);
        run_red(4);
        cyc(0, 1, 0, 0, 1, 0);
        run_red(8);
        cyc(0, 0, 0, 1, 0, 0);
        // 4: abort in WALK with countdown 1, tick in the same cycle
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        // 5: press during FLASH is served next
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 1);
        run_red(3);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        run_red(2);
        // 6: illegal red+green in REQ, then reset mid-WALK with a pending request
        cyc(0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1, 1);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 1, 0);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 1);
        cyc(1, 1, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        // random traffic with held lamp codes
        begin
            logic [2:0] lamps;
            lamps = 3'b100;
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 5) == 0) lamps = 3'($urandom_range(0, 7));
                else if ($urandom_range(0, 3) == 0) lamps = 3'b100;
                cyc(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
                    lamps[2], lamps[1], lamps[0], ($urandom_range(0, 7) == 0));
            end
        end
        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
